frame_probe: RTL

- Downstream observer of the shader pixel stream; taps the final 6-bit colour bus alongside the sync-stage qualifiers.
- On request, captures one full frame and produces:
  - a CRC-16 signature of all active pixels,
  - the colour at a programmable probe coordinate,
  - a geometry check.
- Results are held until acknowledged, so silicon and simulation frames can be compared without a frame buffer.

---
 rtl/tiny_shader_pkg.sv | 15 +
 rtl/frame_probe_crc.sv | 22 ++
 rtl/frame_probe.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/tiny_shader_pkg.sv
// Shared types and constants for the frame probe.
package tiny_shader_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } probe_state_t;

  localparam int unsigned CRC_BITS   = 16;
  localparam int unsigned PIXEL_BITS = 6;
  localparam logic [CRC_BITS-1:0] CRC_POLY = 16'h1021;

endpackage

// File: rtl/frame_probe_crc.sv
// CRC-16-CCITT advanced by one 6-bit pixel, MSB first, no reflection.
module frame_probe_crc
  import tiny_shader_pkg::*;
(
  input  logic [CRC_BITS-1:0]   crc_i,
  input  logic [PIXEL_BITS-1:0] data_i,
  output logic [CRC_BITS-1:0]   next_crc_c
);

  logic [CRC_BITS-1:0] crc_v;

  // Six serial shift/XOR steps unrolled into one cycle.
  always_comb begin
    crc_v = crc_i;
    for (int i = int'(PIXEL_BITS) - 1; i >= 0; i--) begin
      crc_v = {crc_v[CRC_BITS-2:0], 1'b0}
            ^ ({CRC_BITS{crc_v[CRC_BITS-1] ^ data_i[i]}} & CRC_POLY);
    end
    next_crc_c = crc_v;
  end

endmodule

// File: rtl/frame_probe.sv
// Single-frame signature probe: CRC of active pixels, colour at a probe
// coordinate and a line-length / line-count check, held until acknowledged.
module frame_probe
  import tiny_shader_pkg::*;
#(
  parameter int unsigned     WIDTH    = 640,
  parameter int unsigned     HEIGHT   = 480,
  parameter logic [15:0]     CRC_INIT = 16'hFFFF
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [5:0]                rrggbb_i,
  input  logic                      pixel_valid_i,
  input  logic                      frame_start_i,
  input  logic [$clog2(WIDTH)-1:0]  probe_x_i,
  input  logic [$clog2(HEIGHT)-1:0] probe_y_i,
  input  logic                      arm_i,
  input  logic                      ack_i,
  output logic                      busy_o,
  output logic                      result_valid_o,
  output logic [15:0]               crc_o,
  output logic [5:0]                probe_pixel_o,
  output logic                      probe_hit_o,
  output logic                      geometry_err_o
);

  // Counters hold one extra value so a full line/frame reads exactly WIDTH/HEIGHT.
  localparam int unsigned XW  = $clog2(WIDTH + 1);
  localparam int unsigned YW  = $clog2(HEIGHT + 1);
  localparam int unsigned PXW = $clog2(WIDTH);
  localparam int unsigned PYW = $clog2(HEIGHT);

  probe_state_t state_q, state_d;

  logic [XW-1:0]         x_q, x_d;
  logic [YW-1:0]         y_q, y_d;
  logic [CRC_BITS-1:0]   crc_q, crc_d;
  logic [PIXEL_BITS-1:0] pix_q, pix_d;
  logic                  hit_q, hit_d;
  logic                  err_q, err_d;
  logic [PXW-1:0]        probe_x_q;
  logic [PYW-1:0]        probe_y_q;
  logic                  valid_q;
  logic                  latch_probe_c;
  logic                  frame_end_c;
  logic [CRC_BITS-1:0]   crc_step_c;

  frame_probe_crc u_crc (
    .crc_i      (crc_q),
    .data_i     (rrggbb_i),
    .next_crc_c (crc_step_c)
  );

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic and capture control strobes.
  always_comb begin
    state_d       = state_q;
    latch_probe_c = 1'b0;
    frame_end_c   = 1'b0;
    case (state_q)
      IDLE: begin
        if (arm_i) begin
          state_d       = ARMED;
          latch_probe_c = 1'b1;
        end
      end
      ARMED: begin
        if (frame_start_i) state_d = CAPTURE;
      end
      CAPTURE: begin
        if (frame_start_i) begin
          state_d     = DONE;
          frame_end_c = 1'b1;
        end
      end
      DONE: begin
        if (ack_i) begin
          state_d       = arm_i ? ARMED : IDLE;
          latch_probe_c = arm_i;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Accumulation: CRC, probe capture, x/y counting and geometry checks.
  always_comb begin
    x_d   = x_q;
    y_d   = y_q;
    crc_d = crc_q;
    pix_d = pix_q;
    hit_d = hit_q;
    err_d = err_q;
    if (state_q == ARMED && frame_start_i) begin
      x_d   = '0;
      y_d   = '0;
      crc_d = CRC_INIT;
      pix_d = '0;
      hit_d = 1'b0;
      err_d = 1'b0;
    end else if (state_q == CAPTURE) begin
      if (pixel_valid_i) begin
        crc_d = crc_step_c;
        if (x_q == XW'(probe_x_q) && y_q == YW'(probe_y_q)) begin
          pix_d = rrggbb_i;
          hit_d = 1'b1;
        end
        if (x_q == XW'(WIDTH)) err_d = 1'b1;
        else                   x_d   = x_q + XW'(1);
      end else if (valid_q) begin
        if (x_q != XW'(WIDTH)) err_d = 1'b1;
        x_d = '0;
        if (y_q != YW'(HEIGHT)) y_d = y_q + YW'(1);
      end
      if (frame_start_i) begin
        if (pixel_valid_i)       err_d = 1'b1;
        if (y_d != YW'(HEIGHT))  err_d = 1'b1;
      end
    end
  end

  // Datapath registers, probe coordinate latch and line-end edge detector.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      x_q       <= '0;
      y_q       <= '0;
      crc_q     <= '0;
      pix_q     <= '0;
      hit_q     <= 1'b0;
      err_q     <= 1'b0;
      probe_x_q <= '0;
      probe_y_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      crc_q   <= crc_d;
      pix_q   <= pix_d;
      hit_q   <= hit_d;
      err_q   <= err_d;
      valid_q <= pixel_valid_i;
      if (latch_probe_c) begin
        probe_x_q <= probe_x_i;
        probe_y_q <= probe_y_i;
      end
    end
  end

  // Registered status and results; results only move on entry to DONE.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_o         <= 1'b0;
      result_valid_o <= 1'b0;
      crc_o          <= '0;
      probe_pixel_o  <= '0;
      probe_hit_o    <= 1'b0;
      geometry_err_o <= 1'b0;
    end else begin
      busy_o         <= (state_d == ARMED) || (state_d == CAPTURE);
      result_valid_o <= (state_d == DONE);
      if (frame_end_c) begin
        crc_o          <= crc_d;
        probe_pixel_o  <= pix_d;
        probe_hit_o    <= hit_d;
        geometry_err_o <= err_d;
      end
    end
  end

endmodule
